// File: rtl/ext_event_irq_sched_if.sv
// ext_event_irq_sched_if: Avalon-MM slave bus and level interrupt of the event scheduler.
interface ext_event_irq_sched_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/ext_event_irq_sched.sv
// ext_event_irq_sched: captures rising edges on external lines and serves them one at a time
// on a level irq, round-robin, retired by software ACK writes.
module ext_event_irq_sched #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] in_port,
    ext_event_irq_sched_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, state_n;
    logic [N_SRC-1:0] d1, d2, rise, pending, mask, ovf, req, ack_clr, ovf_clr;
    logic [CNT_W-1:0] evcnt;
    logic [3:0] vec_idx, rr, grant;
    logic vec_valid, wr, ack, found;
    logic [31:0] rd;
    assign wr = bus.chipselect & ~bus.write_n;
    assign ack = wr && bus.address == 3'd4 && state == SERVE;
    assign rise = d1 & ~d2;
    assign req = pending & mask;
    assign found = |req;
    assign ack_clr = ack ? N_SRC'(1) << vec_idx : '0;
    assign ovf_clr = (wr && bus.address == 3'd5) ? bus.writedata[N_SRC-1:0] : '0;
    // scan downwards so the lowest offset from rr is the last (winning) assignment
    always_comb begin
        grant = '0;
        for (int k = N_SRC - 1; k >= 0; k--)
            if (req[(int'(rr) + k) % N_SRC]) grant = 4'((int'(rr) + k) % N_SRC);
        state_n = state == IDLE ? (found ? SERVE : IDLE) : (ack ? IDLE : SERVE);
    end
    always_comb begin
        rd = '0;
        case (bus.address)
            3'd0: rd[N_SRC-1:0] = d1;
            3'd1: rd[N_SRC-1:0] = pending;
            3'd2: rd[N_SRC-1:0] = mask;
            3'd3: rd = {vec_valid, 27'd0, vec_idx};
            3'd5: rd[N_SRC-1:0] = ovf;
            3'd6: rd[CNT_W-1:0] = evcnt;
            default: rd = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            pending <= '0;
            mask <= '0;
            ovf <= '0;
            evcnt <= '0;
            vec_idx <= '0;
            vec_valid <= 1'b0;
            rr <= '0;
            bus.readdata <= '0;
            bus.irq <= 1'b0;
        end else begin
            d1 <= in_port;
            d2 <= d1;
            pending <= (pending & ~ack_clr) | rise;
            // an edge on a still-pending source loses an event, unless ACK retires it now
            ovf <= (ovf & ~ovf_clr) | (rise & pending & ~ack_clr);
            if (wr && bus.address == 3'd2) mask <= bus.writedata[N_SRC-1:0];
            if (wr && bus.address == 3'd6) evcnt <= '0;
            else if (ack && ~&evcnt) evcnt <= evcnt + CNT_W'(1);
            if (state == IDLE && found) begin
                vec_idx <= grant;
                vec_valid <= 1'b1;
            end
            if (ack) begin
                vec_valid <= 1'b0;
                rr <= vec_idx == 4'(N_SRC - 1) ? '0 : vec_idx + 4'd1;
            end
            bus.readdata <= rd;
            bus.irq <= state_n == SERVE;
        end
    end
endmodule

// File: tb/tb_ext_event_irq_sched.sv
// tb_ext_event_irq_sched: directed and random stimulus checked every cycle against a
// behavioural model; a CNT_W=4 twin shares all inputs to exercise counter saturation.
module tb_ext_event_irq_sched;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] in_port = '0;
    logic [N-1:0] cur_in = '0;
    int checks = 0;
    int errors = 0;
    ext_event_irq_sched_if bus();
    ext_event_irq_sched_if bus4();
    ext_event_irq_sched #(.N_SRC(N), .CNT_W(16)) dut (.clk(clk), .reset(reset), .in_port(in_port), .bus(bus.slave));
    ext_event_irq_sched #(.N_SRC(N), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .in_port(in_port), .bus(bus4.slave));
    assign bus4.address = bus.address;
    assign bus4.chipselect = bus.chipselect;
    assign bus4.write_n = bus.write_n;
    assign bus4.writedata = bus.writedata;
    always #5 clk = ~clk;

    bit md1[N], md2[N], mp[N], mm[N], mo[N];
    bit srv, mirq;
    int ev, ev4, idx, rr;
    logic [31:0] exp_rd, exp_rd4;

    function automatic logic [31:0] mread(input int a, input int evv);
        logic [31:0] r = '0;
        for (int i = 0; i < N; i++) begin
            if (a == 0) r[i] = md1[i];
            if (a == 1) r[i] = mp[i];
            if (a == 2) r[i] = mm[i];
            if (a == 5) r[i] = mo[i];
        end
        if (a == 3) r = (srv ? 32'h8000_0000 : 32'h0) | 32'(idx);
        if (a == 6) r = 32'(evv);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            md1[i] = 0; md2[i] = 0; mp[i] = 0; mm[i] = 0; mo[i] = 0;
        end
        srv = 0; mirq = 0; ev = 0; ev4 = 0; idx = 0; rr = 0;
        exp_rd = 0; exp_rd4 = 0;
    endtask

    task automatic model_step(input int a, input bit cs, input bit wn, input logic [31:0] wd, input logic [N-1:0] inp);
        bit wr, ack, found, rise, clr;
        int g;
        wr = cs && !wn;
        exp_rd = mread(a, ev);
        exp_rd4 = mread(a, ev4);
        ack = wr && a == 4 && srv;
        found = 0;
        g = 0;
        if (!srv)
            for (int k = 0; k < N; k++)
                if (!found && mp[(rr + k) % N] && mm[(rr + k) % N]) begin
                    found = 1;
                    g = (rr + k) % N;
                end
        for (int i = 0; i < N; i++) begin
            rise = md1[i] && !md2[i];
            clr = ack && idx == i;
            mo[i] = (mo[i] && !(wr && a == 5 && wd[i])) || (rise && mp[i] && !clr);
            mp[i] = (mp[i] && !clr) || rise;
            if (wr && a == 2) mm[i] = wd[i];
            md2[i] = md1[i];
            md1[i] = inp[i];
        end
        if (wr && a == 6) begin
            ev = 0;
            ev4 = 0;
        end else if (ack) begin
            if (ev < 65535) ev++;
            if (ev4 < 15) ev4++;
        end
        if (ack) begin
            rr = (idx + 1) % N;
            srv = 0;
        end else if (found) begin
            srv = 1;
            idx = g;
        end
        mirq = srv;
    endtask

    task automatic step(input int a, input bit cs = 0, input bit wn = 1, input logic [31:0] wd = 0);
        bus.address = 3'(a);
        bus.chipselect = cs;
        bus.write_n = wn;
        bus.writedata = wd;
        in_port = cur_in;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(a, cs, wn, wd, cur_in);
        #1;
        chk("irq", 32'(bus.irq), 32'(mirq));
        chk("readdata", bus.readdata, exp_rd);
        chk("irq_cnt4", 32'(bus4.irq), 32'(mirq));
        chk("readdata_cnt4", bus4.readdata, exp_rd4);
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        step(a, 1, 0, d);
    endtask

    task automatic do_reset();
        cur_in = '0;
        reset = 1'b1;
        step(0);
        chk("rst_irq", 32'(bus.irq), 0);
        chk("rst_rd", bus.readdata, 0);
        reset = 1'b0;
    endtask

    task automatic grant_check(input int exp_idx);
        for (int t = 0; t < 20 && !bus.irq; t++) step(3);
        chk("irq_wait", 32'(bus.irq), 1);
        step(3);
        chk("vector", bus.readdata, 32'h8000_0000 | 32'(exp_idx));
        wr_reg(4, 0);
        chk("irq_after_ack", 32'(bus.irq), 0);
    endtask

    initial begin
        bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
        model_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            step(a);
            chk("idle_read", bus.readdata, 0);
        end
        // single event on line 2
        wr_reg(2, 32'hF);
        cur_in = 4'b0100;
        step(3); step(3);
        chk("irq_before_E2", 32'(bus.irq), 0);
        step(3);
        chk("irq_at_E2", 32'(bus.irq), 1);
        step(3); step(3);
        chk("vector_src2", bus.readdata, 32'h8000_0002);
        cur_in = '0;
        wr_reg(4, 0);
        chk("irq_drop", 32'(bus.irq), 0);
        step(1); step(1);
        chk("pending_clear", bus.readdata, 0);
        step(6); step(6);
        chk("evcnt_one", bus.readdata, 1);
        // simultaneous edges: round-robin from rr=0
        do_reset();
        wr_reg(2, 32'hF);
        cur_in = 4'b1011;
        grant_check(0); grant_check(1); grant_check(3);
        cur_in = '0;
        step(0);
        cur_in = 4'b1001;
        grant_check(0); grant_check(3);
        // overflow on line 1, clear, then edge coinciding with ACK
        cur_in = '0;
        step(0); step(0);
        cur_in = 4'b0010; step(0);
        cur_in = '0; step(0);
        cur_in = 4'b0010; step(0);
        cur_in = '0; step(5); step(5); step(5);
        chk("ovf_set", bus.readdata, 32'h2);
        wr_reg(5, 32'h2);
        step(5); step(5);
        chk("ovf_cleared", bus.readdata, 0);
        chk("still_serving", 32'(bus.irq), 1);
        cur_in = 4'b0010; step(3);
        wr_reg(4, 0);
        chk("ack_irq_low", 32'(bus.irq), 0);
        step(1);
        chk("regrant_irq", 32'(bus.irq), 1);
        step(1);
        chk("pending_kept", bus.readdata, 32'h2);
        step(5); step(5);
        chk("ovf_not_set", bus.readdata, 0);
        grant_check(1);
        // masked source stays pending until unmasked
        cur_in = '0;
        wr_reg(2, 0);
        cur_in = 4'b0001;
        step(1); step(1); step(1); step(1);
        chk("masked_pending", bus.readdata, 32'h1);
        chk("masked_no_irq", 32'(bus.irq), 0);
        wr_reg(2, 32'h1);
        chk("unmask_irq_low", 32'(bus.irq), 0);
        step(1);
        chk("unmask_irq_high", 32'(bus.irq), 1);
        // reset mid-SERVE
        cur_in = '0; step(0);
        wr_reg(2, 32'hF);
        cur_in = 4'hF;
        step(1); step(1); step(1); step(1);
        chk("pending_all", bus.readdata, 32'hF);
        chk("irq_all", 32'(bus.irq), 1);
        do_reset();
        step(1); step(3);
        chk("pending_after_rst", bus.readdata, 0);
        step(0);
        chk("vector_after_rst", bus.readdata, 0);
        // counter saturation on the CNT_W=4 twin
        wr_reg(2, 32'hF);
        for (int n = 0; n < 20; n++) begin
            cur_in = 4'b0001;
            grant_check(0);
            cur_in = '0;
            step(0);
        end
        step(6); step(6);
        chk("evcnt_20", bus.readdata, 20);
        chk("evcnt4_sat", bus4.readdata, 15);
        wr_reg(6, 0);
        step(6); step(6);
        chk("evcnt_cleared", bus.readdata, 0);
        // random traffic checked cycle by cycle against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            cur_in = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 3) wr_reg(4, $urandom);
            else if (r == 3) wr_reg(2, $urandom);
            else if (r == 4) wr_reg(5, $urandom);
            else if (r == 5 && $urandom_range(0, 7) == 0) wr_reg(6, 0);
            else step($urandom_range(0, 7), 1'($urandom), 1'b1, $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
